mult_err_monitor: RTL



---
 rtl/mult_err_monitor_if.sv | 27 ++
 rtl/mult_err_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_err_monitor_if.sv
// Operand/product stream from the approximate multiplier into the
// error monitor; the monitor is the slave, the multiplier side the master.
interface mult_err_monitor_if #(
    parameter int DW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic [2*DW-1:0] in_r;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_r,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_r,
        output in_ready
    );
endinterface

// File: rtl/mult_err_monitor.sv
// Error statistics monitor for the 8x8 approximate multiplier: accepts N
// (a, b, r) triples, compares r to a*b and reports count/sum/max of |a*b-r|.
module mult_err_monitor #(
    parameter int DW    = 8,
    parameter int CNT_W = 16,
    parameter int SUM_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_samples,
    mult_err_monitor_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [SUM_W-1:0]  ed_sum,
    output logic [2*DW-1:0]   ed_max
);

    localparam int PW = 2 * DW;
    // Adder wide enough for either operand plus a carry bit
    localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Run control
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_cnt;

    // Stage 1: captured triple
    logic             r_s1_v;
    logic [DW-1:0]    r_s1_a;
    logic [DW-1:0]    r_s1_b;
    logic [PW-1:0]    r_s1_r;

    // Stage 2: error distance
    logic             r_s2_v;
    logic [PW-1:0]    r_s2_ed;

    // Stage 3: statistics
    logic [CNT_W-1:0] r_err_cnt;
    logic [SUM_W-1:0] r_ed_sum;
    logic [PW-1:0]    r_ed_max;

    logic             w_start_ok;
    logic             w_start_zero;
    logic             w_ready;
    logic             w_xfer;
    logic             w_last;
    logic             w_drained;
    logic [PW-1:0]    w_exact;
    logic [PW-1:0]    w_ed;
    logic [AW-1:0]    w_sum_ext;
    logic [SUM_W-1:0] w_sum_nxt;
    logic [PW-1:0]    w_max_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_start_zero = (cfg_num_samples == '0);

    // Ready depends only on the state register, never on in_valid
    assign w_ready   = (r_state == S_RUN);
    assign w_xfer    = w_ready && bus.in_valid;
    assign w_last    = w_xfer && (r_cnt == (r_num - CNT_W'(1)));
    assign w_drained = !r_s1_v && !r_s2_v;

    // Exact product and symmetric distance to the approximate one
    assign w_exact = PW'(r_s1_a) * PW'(r_s1_b);
    assign w_ed    = (w_exact >= r_s1_r) ? (w_exact - r_s1_r)
                                         : (r_s1_r - w_exact);

    // Saturating accumulation of the distance
    assign w_sum_ext = AW'(r_ed_sum) + AW'(r_s2_ed);
    assign w_sum_nxt = (w_sum_ext > AW'(SUM_MAX)) ? SUM_MAX
                                                  : w_sum_ext[SUM_W-1:0];

    assign w_max_nxt = (r_s2_ed > r_ed_max) ? r_s2_ed : r_ed_max;
    assign w_cnt_nxt = r_err_cnt + CNT_W'(r_s2_ed != '0);

    assign bus.in_ready = w_ready;
    assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done         = (r_state == S_DONE);
    assign err_cnt      = r_err_cnt;
    assign ed_sum       = r_ed_sum;
    assign ed_max       = r_ed_max;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN -> DRAIN -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_start_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample target latched at start, accepted-sample counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num <= '0;
            r_cnt <= '0;
        end else if (w_start_ok) begin
            r_num <= cfg_num_samples;
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Stage 1: capture the triple on each transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
            r_s1_a <= '0;
            r_s1_b <= '0;
            r_s1_r <= '0;
        end else begin
            r_s1_v <= w_xfer;
            if (w_xfer) begin
                r_s1_a <= bus.in_a;
                r_s1_b <= bus.in_b;
                r_s1_r <= bus.in_r;
            end
        end
    end

    // Stage 2: register the error distance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_v  <= 1'b0;
            r_s2_ed <= '0;
        end else begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_ed <= w_ed;
            end
        end
    end

    // Stage 3: fold each distance into the run statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_ed_sum  <= '0;
            r_ed_max  <= '0;
        end else if (w_start_ok) begin
            r_err_cnt <= '0;
            r_ed_sum  <= '0;
            r_ed_max  <= '0;
        end else if (r_s2_v) begin
            r_err_cnt <= w_cnt_nxt;
            r_ed_sum  <= w_sum_nxt;
            r_ed_max  <= w_max_nxt;
        end
    end

endmodule
